// File: rtl/nn_rate_adapter_if.sv
// Host-side and core-side handshake bundle for nn_rate_adapter.
// The adapter takes the slave modport; the host/core environment takes master.
interface nn_rate_adapter_if #(
  parameter int W   = 32,
  parameter int NCH = 3
);
  logic               ce_1;
  logic               ap_start;
  logic               fc0_input_ap_vld;
  logic [NCH*W-1:0]   din;
  logic               ap_done;
  logic               ap_idle;
  logic               ap_ready;
  logic [W-1:0]       layer_out;
  logic               layer_out_ap_vld;
  logic               err_overrun;
  logic               err_timeout;
  logic               core_ce;
  logic               core_ap_start;
  logic               core_in_vld;
  logic [NCH*W-1:0]   core_din;
  logic               core_ap_ready;
  logic               core_ap_done;
  logic [W-1:0]       core_dout;

  modport master (
    output ce_1, ap_start, fc0_input_ap_vld, din,
    output core_ap_ready, core_ap_done, core_dout,
    input  ap_done, ap_idle, ap_ready, layer_out, layer_out_ap_vld,
    input  err_overrun, err_timeout,
    input  core_ce, core_ap_start, core_in_vld, core_din
  );

  modport slave (
    input  ce_1, ap_start, fc0_input_ap_vld, din,
    input  core_ap_ready, core_ap_done, core_dout,
    output ap_done, ap_idle, ap_ready, layer_out, layer_out_ap_vld,
    output err_overrun, err_timeout,
    output core_ce, core_ap_start, core_in_vld, core_din
  );
endinterface

// File: rtl/nn_rate_adapter.sv
// Bridges a full-rate start/done handshake onto a core clocked by a divided
// tick, with input hold, overrun detection and a tick-based timeout.
module nn_rate_adapter #(
  parameter int W   = 32,
  parameter int NCH = 3,
  parameter int DIV = 2,
  parameter int TMO = 1024
) (
  input  logic         clk_1,
  input  logic         ap_rst,
  nn_rate_adapter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
  localparam logic [15:0] TMO_LIM  = 16'(TMO);

  state_t             state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               start_q;
  logic [W-1:0]       lo_q, lo_d;
  logic [NCH*W-1:0]   cdin_q, cdin_d;
  logic               cvld_q, cvld_d;
  logic               ready_q, ready_d;
  logic               ovr_q, ovr_d;
  logic               terr_q, terr_d;

  logic tick;
  logic req_edge;
  logic core_fin;

  assign tick     = bus.ce_1 && (div_q == DIV_LAST);
  assign req_edge = bus.ap_start && !start_q;
  // Done counts in RUN, or in ARM only when the same tick also carries ready.
  assign core_fin = bus.core_ap_done && ((state_q == RUN) || bus.core_ap_ready);

  always_comb begin
    div_d   = div_q;
    state_d = state_q;
    tmo_d   = tmo_q;
    lo_d    = lo_q;
    cdin_d  = cdin_q;
    cvld_d  = cvld_q;
    ready_d = 1'b0;
    ovr_d   = ovr_q;
    terr_d  = terr_q;

    if (bus.ce_1) begin
      div_d = tick ? '0 : div_q + 8'd1;
    end

    if (req_edge && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req_edge) begin
          cdin_d  = bus.din;
          cvld_d  = bus.fc0_input_ap_vld;
          ready_d = 1'b1;
          tmo_d   = '0;
          state_d = ARM;
        end
      end
      ARM, RUN: begin
        if (tick) begin
          tmo_d = tmo_q + 16'd1;
          // A done on the expiring tick still wins over the timeout.
          if (core_fin) begin
            lo_d    = bus.core_dout;
            state_d = DONE;
          end else if (tmo_q + 16'd1 == TMO_LIM) begin
            terr_d  = 1'b1;
            state_d = IDLE;
          end else if ((state_q == ARM) && bus.core_ap_ready) begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (ap_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      lo_q    <= '0;
      cdin_q  <= '0;
      cvld_q  <= 1'b0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tmo_q   <= tmo_d;
      start_q <= bus.ap_start;
      lo_q    <= lo_d;
      cdin_q  <= cdin_d;
      cvld_q  <= cvld_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.ap_idle          = (state_q == IDLE);
  assign bus.ap_done          = (state_q == DONE);
  assign bus.layer_out_ap_vld = (state_q == DONE);
  assign bus.ap_ready         = ready_q;
  assign bus.layer_out        = lo_q;
  assign bus.err_overrun      = ovr_q;
  assign bus.err_timeout      = terr_q;
  assign bus.core_ce          = tick;
  assign bus.core_ap_start    = (state_q == ARM);
  assign bus.core_in_vld      = cvld_q;
  assign bus.core_din         = cdin_q;

endmodule

// File: tb/tb_nn_rate_adapter.sv
// Directed bench for nn_rate_adapter: three instances (DIV=2/TMO=8,
// DIV=1/TMO=1024, DIV=4/TMO=8), each with a small latency-configurable core model.
module tb_nn_rate_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [3];
  logic        ce       [3];
  logic        ap_start [3];
  logic        vld      [3];
  logic [95:0] din_a    [3];
  int          lat      [3];
  logic        ready_en [3];
  logic        done_now [3];
  logic [31:0] dout_val [3];

  logic        ap_done_w [3];
  logic        ap_idle_w [3];
  logic        ap_ready_w[3];
  logic        ovld_w    [3];
  logic        ovr_w     [3];
  logic        terr_w    [3];
  logic        cce_w     [3];
  logic        cstart_w  [3];
  logic        cvld_w    [3];
  logic [31:0] lo_w      [3];
  logic [95:0] cdin_w    [3];

  logic [31:0] exp_q   [3][$];
  logic [95:0] exp_din [3];
  logic        exp_vld [3];
  int          done_cnt [3];
  int          ready_cnt[3];
  int          tick_cnt [3];
  logic [31:0] sb_e;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nn_rate_adapter_if #(.W(32), .NCH(3)) bus ();
    logic busy;
    int   cnt;

    assign bus.ce_1             = ce[g];
    assign bus.ap_start         = ap_start[g];
    assign bus.fc0_input_ap_vld = vld[g];
    assign bus.din              = din_a[g];
    assign bus.core_ap_ready    = bus.core_ap_start && ready_en[g];
    assign bus.core_ap_done     = (busy && (cnt == lat[g] - 1)) ||
                                  (done_now[g] && bus.core_ap_start && ready_en[g]);
    assign bus.core_dout        = bus.core_ap_done ? dout_val[g] : 32'hDEAD_BEEF;

    assign ap_done_w[g]  = bus.ap_done;
    assign ap_idle_w[g]  = bus.ap_idle;
    assign ap_ready_w[g] = bus.ap_ready;
    assign ovld_w[g]     = bus.layer_out_ap_vld;
    assign ovr_w[g]      = bus.err_overrun;
    assign terr_w[g]     = bus.err_timeout;
    assign cce_w[g]      = bus.core_ce;
    assign cstart_w[g]   = bus.core_ap_start;
    assign cvld_w[g]     = bus.core_in_vld;
    assign lo_w[g]       = bus.layer_out;
    assign cdin_w[g]     = bus.core_din;

    nn_rate_adapter #(
      .W  (32),
      .NCH(3),
      .DIV((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
      .TMO((g == 1) ? 1024 : 8)
    ) u_dut (
      .clk_1 (clk),
      .ap_rst(rst[g]),
      .bus   (bus)
    );

    // Core model: accepts start on a tick, raises done lat ticks later.
    always @(posedge clk) begin
      if (rst[g]) begin
        busy <= 1'b0;
        cnt  <= 0;
      end else if (bus.core_ce) begin
        if (bus.core_ap_start && bus.core_ap_ready) begin
          busy <= !done_now[g];
          cnt  <= 0;
        end else if (busy) begin
          if (bus.core_ap_done) busy <= 1'b0;
          else                  cnt  <= cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst[i]) begin
        if (ovld_w[i]) begin
          chk("done_with_vld", ap_done_w[i], 1);
          if (exp_q[i].size() == 0) begin
            chk("unexpected_result", 0, 1);
          end else begin
            sb_e = exp_q[i].pop_front();
            chk("layer_out", lo_w[i], sb_e);
          end
          chk("core_din_held", cdin_w[i], exp_din[i]);
          chk("core_in_vld_held", cvld_w[i], exp_vld[i]);
          chk("latency_ticks", tick_cnt[i], lat[i] + 1);
        end
        if (ap_done_w[i]) done_cnt[i]++;
        if (ap_ready_w[i]) begin
          ready_cnt[i]++;
          tick_cnt[i] = cce_w[i] ? 1 : 0;
        end else if (!ap_idle_w[i] && !ap_done_w[i] && cce_w[i]) begin
          tick_cnt[i]++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    cyc(1);
    ap_start[i] = 1'b1;
    cyc(1);
    ap_start[i] = 1'b0;
  endtask

  task automatic start_txn(input int i, input logic [95:0] d, input logic v,
                           input int l, input logic [31:0] r);
    din_a[i]    = d;
    vld[i]      = v;
    lat[i]      = l;
    dout_val[i] = r;
    exp_din[i]  = d;
    exp_vld[i]  = v;
    exp_q[i].push_back(r);
    pulse_start(i);
  endtask

  task automatic wait_done(input int i, input int prev, input int budget, input string tag);
    int n = 0;
    while (done_cnt[i] <= prev && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, (done_cnt[i] > prev), 1);
  endtask

  task automatic wait_run(input int i, input int budget, input string tag);
    int n = 0;
    while (!(cstart_w[i] == 1'b0 && ap_idle_w[i] == 1'b0) && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, (cstart_w[i] == 1'b0 && ap_idle_w[i] == 1'b0), 1);
  endtask

  initial begin
    int rd, dn, n;
    logic saw_ce;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; ce[i] = 1'b1; ap_start[i] = 1'b0; vld[i] = 1'b0;
      din_a[i] = '0; lat[i] = 4; ready_en[i] = 1'b1; done_now[i] = 1'b0;
      dout_val[i] = '0; exp_din[i] = '0; exp_vld[i] = 1'b0;
      done_cnt[i] = 0; ready_cnt[i] = 0; tick_cnt[i] = 0;
    end

    // Outputs while reset is held
    cyc(3);
    chk("rst_idle", ap_idle_w[0], 1);
    chk("rst_core_start", cstart_w[0], 0);
    chk("rst_core_vld", cvld_w[0], 0);
    chk("rst_done", ap_done_w[0], 0);
    chk("rst_ready", ap_ready_w[0], 0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    cyc(1);
    chk("rst_layer_out", lo_w[0], 0);
    chk("rst_core_din", cdin_w[0], 0);
    chk("rst_errs", {ovr_w[0], terr_w[0]}, 0);

    // Basic transaction, DIV=2, latency 4
    rd = ready_cnt[0]; dn = done_cnt[0];
    start_txn(0, {32'd3, 32'd2, 32'd1}, 1'b1, 4, 32'hA5);
    wait_done(0, dn, 100, "basic_wait");
    chk("basic_idle_after", ap_idle_w[0], 1);
    cyc(4);
    chk("basic_ready_once", ready_cnt[0] - rd, 1);
    chk("basic_done_once", done_cnt[0] - dn, 1);
    chk("basic_hold", lo_w[0], 32'hA5);

    // DIV=1, ap_start held high for 10 cycles
    rd = ready_cnt[1]; dn = done_cnt[1];
    din_a[1] = {32'h11, 32'h22, 32'h33}; vld[1] = 1'b1; lat[1] = 3;
    dout_val[1] = 32'h5A; exp_din[1] = din_a[1]; exp_vld[1] = 1'b1;
    exp_q[1].push_back(32'h5A);
    cyc(1);
    ap_start[1] = 1'b1;
    cyc(10);
    ap_start[1] = 1'b0;
    wait_done(1, dn, 50, "held_wait");
    cyc(3);
    chk("held_ready_once", ready_cnt[1] - rd, 1);
    chk("held_done_once", done_cnt[1] - dn, 1);
    chk("held_no_overrun", ovr_w[1], 0);

    // Ready and done on the same tick, DIV=1
    dn = done_cnt[1];
    done_now[1] = 1'b1;
    start_txn(1, {32'h44, 32'h55, 32'h66}, 1'b1, 0, 32'h99);
    wait_done(1, dn, 20, "same_tick_wait");
    done_now[1] = 1'b0;
    cyc(2);
    chk("same_tick_done_once", done_cnt[1] - dn, 1);

    // Second request edge while in RUN
    rd = ready_cnt[0]; dn = done_cnt[0];
    start_txn(0, {32'd7, 32'd8, 32'd9}, 1'b0, 4, 32'h33);
    wait_run(0, 20, "ovr_reach_run");
    din_a[0] = {32'hF0, 32'hF1, 32'hF2}; vld[0] = 1'b1;
    pulse_start(0);
    wait_done(0, dn, 100, "ovr_wait");
    cyc(6);
    chk("ovr_flag", ovr_w[0], 1);
    chk("ovr_done_once", done_cnt[0] - dn, 1);
    chk("ovr_ready_once", ready_cnt[0] - rd, 1);

    // Timeout: core never finishes, TMO=8
    dn = done_cnt[0];
    lat[0] = 1000;
    pulse_start(0);
    n = 0;
    while (ap_idle_w[0] == 1'b0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("tmo_back_idle", ap_idle_w[0], 1);
    chk("tmo_flag", terr_w[0], 1);
    chk("tmo_ticks", tick_cnt[0], 8);
    chk("tmo_core_start_low", cstart_w[0], 0);
    cyc(3);
    chk("tmo_no_done", done_cnt[0] - dn, 0);

    // DIV=4: ce_1 low for 20 cycles mid-RUN
    dn = done_cnt[2];
    start_txn(2, {32'hAA, 32'hBB, 32'hCC}, 1'b1, 6, 32'h77);
    wait_run(2, 40, "freeze_reach_run");
    cyc(2);
    ce[2] = 1'b0;
    saw_ce = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      saw_ce = saw_ce | cce_w[2];
    end
    chk("freeze_core_ce_low", saw_ce, 0);
    chk("freeze_still_busy", ap_idle_w[2], 0);
    ce[2] = 1'b1;
    wait_done(2, dn, 100, "freeze_wait");
    chk("freeze_no_timeout", terr_w[2], 0);

    // Reset pulsed while in ARM
    ready_en[0] = 1'b0;
    pulse_start(0);
    cyc(2);
    chk("arm_before_rst", cstart_w[0], 1);
    rst[0] = 1'b1;
    cyc(1);
    rst[0] = 1'b0;
    chk("arm_rst_idle", ap_idle_w[0], 1);
    chk("arm_rst_core_start", cstart_w[0], 0);
    chk("arm_rst_errs", {ovr_w[0], terr_w[0]}, 0);
    chk("arm_rst_core_vld", cvld_w[0], 0);
    ready_en[0] = 1'b1;
    rd = ready_cnt[0]; dn = done_cnt[0];
    start_txn(0, {32'h1, 32'h2, 32'h3}, 1'b1, 2, 32'hC3);
    wait_done(0, dn, 100, "post_rst_wait");
    cyc(2);
    chk("post_rst_ready_once", ready_cnt[0] - rd, 1);
    chk("post_rst_done_once", done_cnt[0] - dn, 1);

    chk("sb_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
